// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg
//   Definitions shared by the fetch unit and the control unit of the 24-bit CPU:
//   fetch FSM state type, opcode field position and the opcode encodings.
package instr_fetch_unit_pkg;

    // S_FAULT is only reachable when IFU_ADDR_CHECK_EN is defined.
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_FAULT = 2'd3
    } ifu_state_e;

    localparam int unsigned INSTR_W_CPU = 24;
    localparam int unsigned OPCODE_W    = 6;
    localparam int unsigned OPCODE_HI   = INSTR_W_CPU - 1;
    localparam int unsigned OPCODE_LO   = INSTR_W_CPU - OPCODE_W;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc
//   Combinational next-PC selection for the fetch unit.
//   Ports:
//     PCPlus1      in  PC of the held instruction plus one
//     BranchOffset in  sign-extended word offset, relative to PCPlus1
//     JumpTarget   in  absolute jump address
//     Jump         in  take JumpTarget (wins over Branch)
//     Branch, Zero in  branch taken when both are set
//     NextPC       out selected next PC, modulo 2^PC_W
module next_pc_calc #(
    parameter int unsigned PC_W = 16
) (
    input  logic [PC_W-1:0] PCPlus1,
    input  logic [PC_W-1:0] BranchOffset,
    input  logic [PC_W-1:0] JumpTarget,
    input  logic            Jump,
    input  logic            Branch,
    input  logic            Zero,
    output logic [PC_W-1:0] NextPC
);

    always_comb begin
        NextPC = PCPlus1;
        if (Jump) begin
            NextPC = JumpTarget;
        end else if (Branch && Zero) begin
            // Two's-complement add of the sign-extended offset wraps naturally.
            NextPC = PCPlus1 + BranchOffset;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Non-pipelined front end: holds the PC, fetches one word at a time over a
//   request/ready handshake, keeps it in the instruction register until it is
//   consumed (Stall=0), then redirects the PC and fetches again.
//   Optional: IFU_ADDR_CHECK_EN adds the FetchFault output and traps fetches
//   whose address is >= IMEM_DEPTH.
//   Ports:
//     Clock, Reset                 rising edge clock, synchronous active-high reset
//     ImemReq/ImemAddr             fetch request and word address
//     ImemRdata/ImemReady          returned word, valid when ImemReady=1
//     Stall                        downstream cannot consume the held instruction
//     Jump/Branch/Zero             redirect control, used only on consume
//     BranchOffset/JumpTarget      redirect operands
//     Instr/Opcode/InstrValid      held instruction and its opcode field
//     PC/PCPlus1                   held or in-flight address, and its successor
//     FetchCount                   completed fetches, wrapping
//     FetchFault                   (IFU_ADDR_CHECK_EN only) address trap taken
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned    INSTR_W    = 24,
    parameter int unsigned    PC_W       = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned    IMEM_DEPTH = 65536
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic               ImemReq,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic [INSTR_W-1:0] ImemRdata,
    input  logic               ImemReady,
    input  logic               Stall,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               Zero,
    input  logic [PC_W-1:0]    BranchOffset,
    input  logic [PC_W-1:0]    JumpTarget,
    output logic [INSTR_W-1:0] Instr,
    output logic [5:0]         Opcode,
    output logic               InstrValid,
    output logic [PC_W-1:0]    PC,
    output logic [PC_W-1:0]    PCPlus1,
`ifdef IFU_ADDR_CHECK_EN
    output logic               FetchFault,
`endif
    output logic [15:0]        FetchCount
);

    ifu_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        count_q, count_d;
    logic [PC_W-1:0]    next_pc;
    logic               pc_oob;      // current PC outside the memory
    logic               next_pc_oob; // redirect target outside the memory
    logic               fault;

    next_pc_calc #(
        .PC_W(PC_W)
    ) u_next_pc_calc (
        .PCPlus1     (PCPlus1),
        .BranchOffset(BranchOffset),
        .JumpTarget  (JumpTarget),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .NextPC      (next_pc)
    );

`ifdef IFU_ADDR_CHECK_EN
    assign pc_oob      = 32'(pc_q) >= IMEM_DEPTH;
    assign next_pc_oob = 32'(next_pc) >= IMEM_DEPTH;
    assign FetchFault  = fault;
`else
    logic unused_depth;
    assign unused_depth = ^IMEM_DEPTH ^ fault;
    assign pc_oob       = 1'b0;
    assign next_pc_oob  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        count_d    = count_q;
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            S_RESET: begin
                state_d = pc_oob ? S_FAULT : S_FETCH;
            end
            S_FETCH: begin
                ImemReq = 1'b1;
                if (ImemReady) begin
                    instr_d = ImemRdata;
                    count_d = count_q + 16'd1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                InstrValid = 1'b1;
                if (!Stall) begin
                    pc_d    = next_pc;
                    state_d = next_pc_oob ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus1    = pc_q + PC_W'(1);
    assign Instr      = instr_q;
    assign Opcode     = instr_q[INSTR_W-1 -: 6];
    assign FetchCount = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Self-checking bench: directed start-up/stall/wait/reset sequences, a table of
//   redirect vectors, and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ImemReq;
    logic [15:0] ImemAddr;
    logic [23:0] ImemRdata;
    logic        ImemReady;
    logic        Stall, Jump, Branch, Zero;
    logic [15:0] BranchOffset, JumpTarget;
    logic [23:0] Instr;
    logic [5:0]  Opcode;
    logic        InstrValid;
    logic [15:0] PC, PCPlus1, FetchCount;
`ifdef IFU_ADDR_CHECK_EN
    logic        FetchFault;
`endif
    logic        rd_junk;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 24'h8C0001;
        return {a[5:0] ^ 6'h2A, 2'b01, a};
    endfunction

    assign ImemRdata = (ImemReady && !rd_junk) ? mem_word(ImemAddr) : 24'hBADBAD;

    instr_fetch_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemRdata   (ImemRdata),
        .ImemReady   (ImemReady),
        .Stall       (Stall),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .BranchOffset(BranchOffset),
        .JumpTarget  (JumpTarget),
        .Instr       (Instr),
        .Opcode      (Opcode),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .PCPlus1     (PCPlus1),
`ifdef IFU_ADDR_CHECK_EN
        .FetchFault  (FetchFault),
`endif
        .FetchCount  (FetchCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Advance until an instruction is held, bounded.
    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (InstrValid === 1'b1) return;
            tick();
        end
        check("wait_valid_timeout", {31'b0, InstrValid}, 32'd1);
    endtask

    // Consume the held instruction with the given redirect, then hold further ones.
    task automatic consume(input logic j, input logic b, input logic z,
                           input logic [15:0] off, input logic [15:0] tgt);
        Stall = 1'b0; Jump = j; Branch = b; Zero = z;
        BranchOffset = off; JumpTarget = tgt;
        tick();
        Stall = 1'b1; Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        BranchOffset = 16'hAAAA; JumpTarget = 16'h5555;
    endtask

    typedef struct {
        string       name;
        logic [15:0] start_pc;
        logic        j, b, z;
        logic [15:0] off, tgt;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    // Transaction-level model state for the random run.
    int          m_phase;   // 0: just reset, 1: request outstanding, 2: holding
    logic [15:0] m_pc;
    logic [23:0] m_instr;
    logic [15:0] m_count;

    initial begin
        vecs[0] = '{"br_taken_back",  16'h0005, 1'b0, 1'b1, 1'b1, 16'hFFFE, 16'h0000, 16'h0004};
        vecs[1] = '{"br_not_taken",   16'h0005, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0006};
        vecs[2] = '{"jump_over_br",   16'h0005, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0040, 16'h0040};
        vecs[3] = '{"seq_wrap",       16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0000};
        vecs[4] = '{"br_fwd_wrap",    16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h1111, 16'h0002};
        vecs[5] = '{"jump_no_branch", 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h1234, 16'h1234};

        Reset = 1'b1; ImemReady = 1'b1; Stall = 1'b0; rd_junk = 1'b0;
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; BranchOffset = '0; JumpTarget = '0;

        // Reset state
        tick();
        check("rst_pc", PC, 0);
        check("rst_instr", Instr, 0);
        check("rst_opcode", Opcode, 0);
        check("rst_valid", InstrValid, 0);
        check("rst_req", ImemReq, 0);
        check("rst_addr", ImemAddr, 0);
        check("rst_pcplus1", PCPlus1, 1);
        check("rst_count", FetchCount, 0);
`ifdef IFU_ADDR_CHECK_EN
        check("rst_fault", FetchFault, 0);
`endif
        Reset = 1'b0;

        // First fetch with zero-wait memory
        tick();
        check("c1_req", ImemReq, 1);
        check("c1_addr", ImemAddr, 0);
        tick();
        check("c2_valid", InstrValid, 1);
        check("c2_opcode", Opcode, 6'b100011);
        check("c2_pc", PC, 0);
        check("c2_count", FetchCount, 1);
        check("c2_instr", Instr, 24'h8C0001);

        // Sequential fetch, 2-cycle spacing
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("seq_req", ImemReq, 1);
            check("seq_addr", ImemAddr, k);
            tick();
            check("seq_valid", InstrValid, 1);
        end

        // Stall holds the instruction; ImemReady while holding is ignored
        Stall = 1'b1; rd_junk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_instr", Instr, mem_word(16'h0003));
            check("stall_pc", PC, 3);
            check("stall_valid", InstrValid, 1);
            check("stall_req", ImemReq, 0);
            check("stall_count", FetchCount, 4);
        end
        rd_junk = 1'b0;
        consume(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("unstall_req", ImemReq, 1);
        check("unstall_addr", ImemAddr, 4);

        // Redirect vectors
        foreach (vecs[i]) begin
            wait_valid();
            consume(1'b1, 1'b0, 1'b0, 16'h0000, vecs[i].start_pc);
            wait_valid();
            check({vecs[i].name, "_start"}, PC, vecs[i].start_pc);
            consume(vecs[i].j, vecs[i].b, vecs[i].z, vecs[i].off, vecs[i].tgt);
            check({vecs[i].name, "_req"}, ImemReq, 1);
            check({vecs[i].name, "_addr"}, ImemAddr, vecs[i].exp_addr);
        end

        // Memory wait states, then reset during the wait with a concurrent ready
        ImemReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wait_req", ImemReq, 1);
            check("wait_addr", ImemAddr, 16'h1234);
            check("wait_valid", InstrValid, 0);
        end
        Reset = 1'b1; ImemReady = 1'b1;
        tick();
        check("midrst_req", ImemReq, 0);
        check("midrst_pc", PC, 0);
        check("midrst_count", FetchCount, 0);
        check("midrst_instr", Instr, 0);
        check("midrst_valid", InstrValid, 0);
        Reset = 1'b0;

        // Randomized run against the model
        m_phase = 0; m_pc = 16'h0000; m_instr = 24'h0; m_count = 16'h0;
        for (int i = 0; i < 600; i++) begin
            ImemReady    = ($urandom_range(0, 9) < 6);
            Stall        = ($urandom_range(0, 3) == 0);
            Jump         = ($urandom_range(0, 7) == 0);
            Branch       = ($urandom_range(0, 3) == 0);
            Zero         = 1'($urandom_range(0, 1));
            BranchOffset = 16'($urandom);
            JumpTarget   = 16'($urandom);
            @(posedge Clock);
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (ImemReady) begin
                    m_instr = mem_word(m_pc);
                    m_count = m_count + 16'd1;
                    m_phase = 2;
                end
            end else if (!Stall) begin
                if (Jump) m_pc = JumpTarget;
                else m_pc = m_pc + 16'd1 + ((Branch && Zero) ? BranchOffset : 16'd0);
                m_phase = 1;
            end
            #1;
            check("rnd_req", ImemReq, (m_phase == 1));
            check("rnd_valid", InstrValid, (m_phase == 2));
            check("rnd_addr", ImemAddr, m_pc);
            check("rnd_pcplus1", PCPlus1, 16'(m_pc + 16'd1));
            check("rnd_instr", Instr, m_instr);
            check("rnd_opcode", Opcode, m_instr[23:18]);
            check("rnd_count", FetchCount, m_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
